// File: rtl/tx_serializer_gen.sv
// Parallel-to-serial converter for the SERDES TX path: valid/ready word intake,
// per-word bit order, framing strobes, and a one-word holding buffer for gapless streaming.
module tx_serializer_gen #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              msb_first,
  output logic              data_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t            state, nxt_state;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic [DATA_W-1:0] sh_data, nxt_sh_data, buf_data;
  logic              sh_msb, nxt_sh_msb, buf_msb;
  logic              buf_full, nxt_buf_full, buf_wr;
  logic              accept, load_slot;

  function automatic logic pick_bit(input logic [DATA_W-1:0] d, input logic msb,
                                    input logic [CNT_W-1:0] idx);
    logic [CNT_W-1:0] pos;
    pos = msb ? (LAST - idx) : idx;
    return d[pos];
  endfunction

  assign data_ready = ~rst & ~buf_full;
  assign accept     = data_valid & data_ready;
  assign load_slot  = (state == IDLE) || (cnt == LAST);

  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    nxt_sh_data  = sh_data;
    nxt_sh_msb   = sh_msb;
    nxt_buf_full = buf_full;
    buf_wr       = 1'b0;
    if (load_slot) begin
      nxt_cnt = '0;
      // The buffered word always wins; data_ready is low while it is held.
      if (buf_full) begin
        nxt_state    = SHIFT;
        nxt_sh_data  = buf_data;
        nxt_sh_msb   = buf_msb;
        nxt_buf_full = 1'b0;
      end else if (accept) begin
        nxt_state   = SHIFT;
        nxt_sh_data = data_in;
        nxt_sh_msb  = msb_first;
      end else begin
        nxt_state = IDLE;
      end
    end else begin
      nxt_cnt = cnt + 1'b1;
      if (accept) begin
        buf_wr       = 1'b1;
        nxt_buf_full = 1'b1;
      end
    end
  end

  // Control and registered outputs: output bits reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      buf_full    <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      buf_full    <= nxt_buf_full;
      ser_valid   <= (nxt_state == SHIFT);
      ser_out     <= (nxt_state == SHIFT) & pick_bit(nxt_sh_data, nxt_sh_msb, nxt_cnt);
      frame_start <= (nxt_state == SHIFT) && (nxt_cnt == '0);
      frame_end   <= (nxt_state == SHIFT) && (nxt_cnt == LAST);
      busy        <= (nxt_state == SHIFT) || nxt_buf_full;
    end
  end

  // Datapath storage: contents are only meaningful while the matching control flag is set.
  always_ff @(posedge clk) begin
    sh_data <= nxt_sh_data;
    sh_msb  <= nxt_sh_msb;
    if (buf_wr) begin
      buf_data <= data_in;
      buf_msb  <= msb_first;
    end
  end

endmodule
